// File: rtl/fp_pkg.sv
// fp_pkg: shared flag indices, operand classes and constants for the FP add/sub pipeline.
package fp_pkg;
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_INVALID   = 4;
  localparam int GRS_W          = 3;
  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} fp_class_e;
  function automatic logic [127:0] qnan(input int ew, input int fw);
    qnan = '0;
    for (int i = 0; i < ew; i++) qnan[fw+i] = 1'b1;
    qnan[fw-1] = 1'b1;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int W = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (x[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 add/sub (align, add, normalise/round) with valid/ready at both ends.
// FP_ADDSUB_DENORM_EN enables subnormal inputs/outputs; without it they flush to signed zero.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       flags
);
  localparam int SW = FRAC_W + 1 + GRS_W;
  localparam int LZ_W = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] SWE = EXP_W'(SW);
  localparam logic [W-1:0] QN = W'(qnan(EXP_W, FRAC_W));

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             zsign;
    logic             sub;
    logic             flush;
    logic             spec;
    logic             inv;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sig_a;
    logic [SW-1:0]    sig_b;
    logic [W-1:0]     sres;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             zsign;
    logic             flush;
    logic             spec;
    logic             inv;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
    logic [W-1:0]     sres;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             valid;
    logic [W-1:0]     res;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t s1_d, s1_q, s1_n;
  s2_t s2_d, s2_q, s2_n;
  s3_t s3_d, s3_q, s3_n;
  logic adv;

  assign adv       = ~s3_q.valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_q.valid;
  assign result    = s3_q.res;
  assign out_tag   = s3_q.tag;
  assign flags     = s3_q.flags;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    if (&e) begin
      if (f == '0) return CLS_INF;
      if (f[FRAC_W-1]) return CLS_QNAN;
      return CLS_SNAN;
    end
    if (e != '0) return CLS_NORM;
    if (f == '0) return CLS_ZERO;
    return CLS_SUB;
  endfunction

  logic                   sa, sb, swap, nan, snan, infinf, flush;
  logic [EXP_W-1:0]       ea, eb, xa, xb, xg, xl, d;
  logic [FRAC_W-1:0]      fa, fb;
  logic [FRAC_W:0]        ma, mb, mg, ml;
  logic [SW-1:0]          ext, shr, lost;
  fp_class_e              ca, cb;

  always_comb begin
    sa = a[W-1];
    ea = a[W-2 -: EXP_W];
    fa = a[FRAC_W-1:0];
    sb = b[W-1] ^ sub;
    eb = b[W-2 -: EXP_W];
    fb = b[FRAC_W-1:0];
    ca = classify(ea, fa);
    cb = classify(eb, fb);
`ifdef FP_ADDSUB_DENORM_EN
    ma = {|ea, fa};
    mb = {|eb, fb};
    flush = 1'b0;
`else
    ma = (ea == '0) ? '0 : {1'b1, fa};
    mb = (eb == '0) ? '0 : {1'b1, fb};
    flush = (ca == CLS_SUB) | (cb == CLS_SUB);
`endif
    // exponent 0 sits at the same scale as exponent 1
    xa = (ea == '0) ? EXP_W'(1) : ea;
    xb = (eb == '0) ? EXP_W'(1) : eb;
    swap = {xb, mb} > {xa, ma};
    xg = swap ? xb : xa;
    xl = swap ? xa : xb;
    mg = swap ? mb : ma;
    ml = swap ? ma : mb;
    d = xg - xl;
    ext = {ml, {GRS_W{1'b0}}};
    shr = (d >= SWE) ? '0 : ext >> d;
    lost = (d >= SWE) ? ext : ext & ~({SW{1'b1}} << d);
    snan = (ca == CLS_SNAN) | (cb == CLS_SNAN);
    nan = snan | (ca == CLS_QNAN) | (cb == CLS_QNAN);
    infinf = (ca == CLS_INF) & (cb == CLS_INF) & (sa ^ sb);
    s1_n = '{valid: in_valid, sign: swap ? sb : sa, zsign: sa & sb, sub: sa ^ sb, flush: flush,
             spec: nan | (ca == CLS_INF) | (cb == CLS_INF), inv: snan | infinf, exp: xg,
             sig_a: {mg, {GRS_W{1'b0}}}, sig_b: {shr[SW-1:1], shr[0] | (|lost)},
             sres: (nan | infinf) ? QN : {(ca == CLS_INF) ? sa : sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}},
             tag: in_tag};
    s1_d = adv ? s1_n : s1_q;
  end

  always_comb begin
    s2_n = '{valid: s1_q.valid, sign: s1_q.sign, zsign: s1_q.zsign, flush: s1_q.flush,
             spec: s1_q.spec, inv: s1_q.inv, exp: s1_q.exp,
             sum: s1_q.sub ? {1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b} : {1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b},
             sres: s1_q.sres, tag: s1_q.tag};
    s2_d = adv ? s2_n : s2_q;
  end

  logic [LZ_W-1:0]         z;
  logic [EXP_W:0]          ze, ex1, sh, en, e;
  logic [SW-1:0]           m;
  logic [EXP_W+FRAC_W:0]   pk;
  logic                    carry, zs, tiny, inc, ovf, inx;
  logic [W-1:0]            res;
  logic [4:0]              fl;

  fp_lzc #(.W(SW)) u_lzc (.x(s2_q.sum[SW-1:0]), .cnt(z));

  always_comb begin
    carry = s2_q.sum[SW];
    zs = s2_q.sum == '0;
    ze = (EXP_W + 1)'(z);
    ex1 = {1'b0, s2_q.exp};
`ifdef FP_ADDSUB_DENORM_EN
    sh = (ze < ex1) ? ze : ex1 - 1'b1;
    en = (ze < ex1) ? ex1 - ze : '0;
    tiny = 1'b0;
`else
    sh = ze;
    en = ex1 - ze;
    tiny = ~carry & ~zs & (ze >= ex1);
`endif
    m = carry ? {s2_q.sum[SW:2], |s2_q.sum[1:0]} : s2_q.sum[SW-1:0] << sh;
    e = carry ? ex1 + 1'b1 : en;
    inc = m[2] & (m[1] | m[0] | m[3]);
    inx = |m[2:0];
    // the rounding carry ripples straight into the exponent field
    pk = {e, m[SW-2:GRS_W]} + (EXP_W + FRAC_W + 1)'(inc);
    ovf = pk[EXP_W+FRAC_W:FRAC_W] >= {1'b0, {EXP_W{1'b1}}};
    res = s2_q.spec ? s2_q.sres :
          zs ? {s2_q.zsign, {(W-1){1'b0}}} :
          tiny ? {s2_q.sign, {(W-1){1'b0}}} :
          ovf ? {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
          {s2_q.sign, pk[EXP_W+FRAC_W-1:0]};
    fl = '0;
    fl[FLAG_INVALID] = s2_q.spec & s2_q.inv;
    fl[FLAG_OVERFLOW] = ~s2_q.spec & ~zs & ~tiny & ovf;
    fl[FLAG_INEXACT] = ~s2_q.spec & (s2_q.flush | tiny | (~zs & (ovf | inx)));
    fl[FLAG_UNDERFLOW] = ~s2_q.spec & (s2_q.flush | tiny |
                         (~zs & ~ovf & inx & (pk[EXP_W+FRAC_W-1:FRAC_W] == '0)));
    fl[FLAG_ZERO] = ~s2_q.spec & (res[W-2:0] == '0);
    s3_n = '{valid: s2_q.valid, res: res, flags: fl, tag: s2_q.tag};
    s3_d = adv ? s3_n : s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: scoreboard bench for the binary32 add/sub pipeline.
module tb_fp_addsub_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [31:0] a = 0, b = 0, result;
  logic [3:0] in_tag = 0, out_tag;
  logic [4:0] flags;
  int checks = 0, errors = 0, n_out = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb_q[$];

  fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL output: unexpected result %h tag %0d, want none", result, out_tag);
      end else begin
        e = sb_q.pop_front();
        n_out++;
        if (result !== e.res || flags !== e.fl || out_tag !== e.tag) begin
          errors++;
          $display("FAIL output: got %h flags %b tag %0d, want %h flags %b tag %0d",
                   result, flags, out_tag, e.res, e.fl, e.tag);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                       input logic [3:0] ti, input logic [31:0] er, input logic [4:0] ef);
    int n = 0;
    logic acc = 0;
    a = ai; b = bi; sub = si; in_tag = ti; in_valid = 1;
    sb_q.push_back('{er, ef, ti});
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept: tag %0d in_ready stayed 0, want 1", ti);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 0 || result !== 0 || out_tag !== 0 || flags !== 0) begin
      errors++;
      $display("FAIL reset: valid %b result %h tag %0d flags %b, want all 0", out_valid, result, out_tag, flags);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    checks++;
    if (in_ready !== 1 || out_valid !== 0) begin
      errors++;
      $display("FAIL reset_ready: in_ready %b out_valid %b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    issue(32'h3F800000, 32'h40000000, 0, 4'd1, 32'h40400000, 5'b00000);
    issue(32'h3F800000, 32'h3F800000, 1, 4'd2, 32'h00000000, 5'b00001);
    issue(32'h80000000, 32'h80000000, 0, 4'd3, 32'h80000000, 5'b00001);
    issue(32'h3FC00000, 32'hBF000000, 0, 4'd4, 32'h3F800000, 5'b00000);
    issue(32'h40400000, 32'h3F800000, 1, 4'd5, 32'h40000000, 5'b00000);
    issue(32'h3F800000, 32'h40000000, 1, 4'd6, 32'hBF800000, 5'b00000);
    issue(32'hBF800000, 32'hC0000000, 0, 4'd7, 32'hC0400000, 5'b00000);
    drain();
  endtask

  task automatic test_special();
    issue(32'h7F800000, 32'h7F800000, 1, 4'd1, 32'h7FC00000, 5'b10000);
    issue(32'h7F800001, 32'h3F800000, 0, 4'd2, 32'h7FC00000, 5'b10000);
    issue(32'h7FC00000, 32'h3F800000, 0, 4'd3, 32'h7FC00000, 5'b00000);
    issue(32'h7F800000, 32'h3F800000, 0, 4'd4, 32'h7F800000, 5'b00000);
    issue(32'h3F800000, 32'h7F800000, 1, 4'd5, 32'hFF800000, 5'b00000);
    issue(32'h7F800000, 32'h7F800000, 0, 4'd6, 32'h7F800000, 5'b00000);
    drain();
  endtask

  task automatic test_round();
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 4'd1, 32'h7F800000, 5'b01010);
    issue(32'h3F800000, 32'h33800000, 0, 4'd2, 32'h3F800000, 5'b00010);
    issue(32'h3F800000, 32'h33C00000, 0, 4'd3, 32'h3F800001, 5'b00010);
    issue(32'h3F800001, 32'h33800000, 0, 4'd4, 32'h3F800002, 5'b00010);
    issue(32'hBF800000, 32'hB3800000, 0, 4'd5, 32'hBF800000, 5'b00010);
    drain();
  endtask

  task automatic test_denorm();
`ifdef FP_ADDSUB_DENORM_EN
    issue(32'h00000001, 32'h00000001, 0, 4'd1, 32'h00000002, 5'b00000);
    issue(32'h00800001, 32'h00800000, 1, 4'd2, 32'h00000001, 5'b00000);
`else
    issue(32'h00000001, 32'h00000001, 0, 4'd1, 32'h00000000, 5'b00111);
    issue(32'h00800001, 32'h00800000, 1, 4'd2, 32'h00000000, 5'b00111);
`endif
    drain();
  endtask

  task automatic test_latency();
    int n = 1;
    issue(32'h3F800000, 32'h40000000, 0, 4'd9, 32'h40400000, 5'b00000);
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges, want 3", n);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [6] = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h7F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vb [6] = '{32'h40000000, 32'hBF000000, 32'h3F800000, 32'h3F800000, 32'h33C00000, 32'h3F800000};
    logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] vr [6] = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h7F800000, 32'h3F800001, 32'h00000000};
    logic [4:0]  vf [6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00001};
    int n0 = n_out;
    fork
      for (int i = 0; i < 6; i++) issue(va[i], vb[i], vs[i], 4'(i), vr[i], vf[i]);
      begin
        out_ready = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1 || in_ready !== 0) begin
          errors++;
          $display("FAIL stall: out_valid %b in_ready %b, want 1 0", out_valid, in_ready);
        end
        checks++;
        if (result !== 32'h40400000 || out_tag !== 0) begin
          errors++;
          $display("FAIL hold: result %h tag %0d, want 40400000 tag 0", result, out_tag);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    checks++;
    if (n_out - n0 != 6) begin
      errors++;
      $display("FAIL count: %0d results, want 6", n_out - n0);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 0;
    for (int i = 0; i < 4; i++) issue(32'h3F800000, 32'h40000000, 0, 4'(i), 32'h40400000, 5'b00000);
    #2 rst_n = 0;
    sb_q.delete();
    #1;
    checks++;
    if (out_valid !== 0 || result !== 0 || flags !== 0) begin
      errors++;
      $display("FAIL reset_mid: out_valid %b result %h flags %b, want 0 0 0", out_valid, result, flags);
    end
    @(posedge clk);
    #1 rst_n = 1;
    repeat (4) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flushed: out_valid %b after reset, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_round();
    test_denorm();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
